// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: broadcast packet layout, FU slot numbering and the
// round-robin pointer advance helper.
package cdb_arbiter_pkg;

   localparam int NUM_FU  = 4;
   localparam int XLEN    = 32;
   localparam int PRF_LEN = 6;
   localparam int ROB_LEN = 5;

   localparam int FU_ALU  = 0;
   localparam int FU_MUL  = 1;
   localparam int FU_LOAD = 2;
   localparam int FU_BR   = 3;

   typedef struct packed {
      logic               valid;
      logic [XLEN-1:0]    value;
      logic [PRF_LEN-1:0] prf_idx;
      logic [ROB_LEN-1:0] rob_idx;
      logic [XLEN-1:0]    PC;
   } CDB_PACKET;

   // The pointer moves to the slot just past the winner, wrapping at n.
   function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU request/grant bus plus the registered CDB broadcast it feeds.
// master = FU/consumer side, slave = arbiter.
interface cdb_arbiter_if #(
   parameter int NUM_FU  = 4,
   parameter int XLEN    = 32,
   parameter int PRF_LEN = 6,
   parameter int ROB_LEN = 5
);
   logic [NUM_FU-1:0]         fu_valid;
   logic [NUM_FU*XLEN-1:0]    fu_value;
   logic [NUM_FU*PRF_LEN-1:0] fu_prf_idx;
   logic [NUM_FU*ROB_LEN-1:0] fu_rob_idx;
   logic [NUM_FU*XLEN-1:0]    fu_PC;
   logic [NUM_FU-1:0]         fu_grant;

   logic                      cdb_valid;
   logic [XLEN-1:0]           cdb_value;
   logic [PRF_LEN-1:0]        cdb_prf_idx;
   logic [ROB_LEN-1:0]        cdb_rob_idx;
   logic [XLEN-1:0]           cdb_PC;
   logic [NUM_FU-1:0]         cdb_source;

   modport master (
      output fu_valid, fu_value, fu_prf_idx, fu_rob_idx, fu_PC,
      input  fu_grant,
      input  cdb_valid, cdb_value, cdb_prf_idx, cdb_rob_idx, cdb_PC, cdb_source
   );

   modport slave (
      input  fu_valid, fu_value, fu_prf_idx, fu_rob_idx, fu_PC,
      output fu_grant,
      output cdb_valid, cdb_value, cdb_prf_idx, cdb_rob_idx, cdb_PC, cdb_source
   );
endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational picker: first set request searching upward from ptr_i with
// wrap; returns one-hot grant and binary index of the winner.
module cdb_arbiter_rr_picker #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     grant_o,
   output logic [IDX_W-1:0] idx_o
);

   logic             found;
   logic [IDX_W:0]   pos;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      pos     = '0;
      for (int k = 0; k < N; k++) begin
         pos = {1'b0, ptr_i} + (IDX_W+1)'(k);
         if (pos >= (IDX_W+1)'(N)) pos = pos - (IDX_W+1)'(N);
         if (!found && req_i[pos[IDX_W-1:0]]) begin
            found                    = 1'b1;
            grant_o[pos[IDX_W-1:0]]  = 1'b1;
            idx_o                    = pos[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// FU-to-CDB arbiter: same-cycle grant, one-cycle registered broadcast.
// Define CDB_ROUND_ROBIN_EN for round-robin; otherwise lowest index wins.
module cdb_arbiter #(
   parameter int NUM_FU  = 4,
   parameter int XLEN    = 32,
   parameter int PRF_LEN = 6,
   parameter int ROB_LEN = 5
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          squash,
   cdb_arbiter_if.slave  bus
);
   import cdb_arbiter_pkg::*;

   localparam int IDX_W = $clog2(NUM_FU);

   logic [NUM_FU-1:0]  pick, grant;
   logic [IDX_W-1:0]   ptr, win_idx;
   logic               grant_any;

   logic               cdb_valid_q, cdb_valid_d;
   logic [XLEN-1:0]    cdb_value_q, cdb_value_d;
   logic [PRF_LEN-1:0] cdb_prf_idx_q, cdb_prf_idx_d;
   logic [ROB_LEN-1:0] cdb_rob_idx_q, cdb_rob_idx_d;
   logic [XLEN-1:0]    cdb_PC_q, cdb_PC_d;
   logic [NUM_FU-1:0]  cdb_source_q, cdb_source_d;

   cdb_arbiter_rr_picker #(.N(NUM_FU), .IDX_W(IDX_W)) u_rr_picker (
      .req_i   (bus.fu_valid),
      .ptr_i   (ptr),
      .grant_o (pick),
      .idx_o   (win_idx)
   );

   // Requests are never latched: a squashed or reset cycle simply grants nobody.
   assign grant        = (reset || squash) ? '0 : pick;
   assign grant_any    = |grant;
   assign bus.fu_grant = grant;

`ifdef CDB_ROUND_ROBIN_EN
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_any) rr_ptr_d = IDX_W'(rr_next(32'(win_idx), NUM_FU));
   end

   always_ff @(posedge clock) begin
      if (reset) rr_ptr_q <= '0;
      else       rr_ptr_q <= rr_ptr_d;
   end

   assign ptr = rr_ptr_q;
`else
   assign ptr = '0;
`endif

   always_comb begin
      cdb_valid_d   = grant_any;
      cdb_source_d  = grant;
      cdb_value_d   = cdb_value_q;
      cdb_prf_idx_d = cdb_prf_idx_q;
      cdb_rob_idx_d = cdb_rob_idx_q;
      cdb_PC_d      = cdb_PC_q;
      if (grant_any) begin
         cdb_value_d   = bus.fu_value[int'(win_idx)*XLEN +: XLEN];
         cdb_prf_idx_d = bus.fu_prf_idx[int'(win_idx)*PRF_LEN +: PRF_LEN];
         cdb_rob_idx_d = bus.fu_rob_idx[int'(win_idx)*ROB_LEN +: ROB_LEN];
         cdb_PC_d      = bus.fu_PC[int'(win_idx)*XLEN +: XLEN];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cdb_valid_q   <= 1'b0;
         cdb_value_q   <= '0;
         cdb_prf_idx_q <= '0;
         cdb_rob_idx_q <= '0;
         cdb_PC_q      <= '0;
         cdb_source_q  <= '0;
      end else begin
         cdb_valid_q   <= cdb_valid_d;
         cdb_value_q   <= cdb_value_d;
         cdb_prf_idx_q <= cdb_prf_idx_d;
         cdb_rob_idx_q <= cdb_rob_idx_d;
         cdb_PC_q      <= cdb_PC_d;
         cdb_source_q  <= cdb_source_d;
      end
   end

   assign bus.cdb_valid   = cdb_valid_q;
   assign bus.cdb_value   = cdb_value_q;
   assign bus.cdb_prf_idx = cdb_prf_idx_q;
   assign bus.cdb_rob_idx = cdb_rob_idx_q;
   assign bus.cdb_PC      = cdb_PC_q;
   assign bus.cdb_source  = cdb_source_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: FU request model, expected-grant model and a
// scoreboard of expected CDB broadcasts, for either arbitration mode.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N = 4;

   logic clock  = 1'b0;
   logic reset  = 1'b1;
   logic squash = 1'b0;

   always #5 clock = ~clock;

   cdb_arbiter_if bus ();

   cdb_arbiter dut (
      .clock  (clock),
      .reset  (reset),
      .squash (squash),
      .bus    (bus)
   );

   typedef struct {
      logic        v;
      logic        chk;
      logic [31:0] val;
      logic [5:0]  prf;
      logic [4:0]  rob;
      logic [31:0] pc;
      logic [3:0]  src;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   m_ptr  = 0;

   logic [31:0] d_val[N];
   logic [31:0] d_pc[N];
   logic [5:0]  d_prf[N];
   logic [4:0]  d_rob[N];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] model_grant(input logic [3:0] req, input logic sq, input logic rs);
      if (rs || sq) return 4'b0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (m_ptr + k) % N;
         if (req[j]) return 4'(1 << j);
      end
      return 4'b0;
   endfunction

   task automatic set_fu(input int i, input logic [31:0] v, input logic [5:0] p,
                         input logic [4:0] r, input logic [31:0] pc);
      d_val[i] = v; d_prf[i] = p; d_rob[i] = r; d_pc[i] = pc;
   endtask

   task automatic drive_bus();
      for (int i = 0; i < N; i++) begin
         bus.fu_value[i*32 +: 32]  = d_val[i];
         bus.fu_PC[i*32 +: 32]     = d_pc[i];
         bus.fu_prf_idx[i*6 +: 6]  = d_prf[i];
         bus.fu_rob_idx[i*5 +: 5]  = d_rob[i];
      end
   endtask

   // One clock cycle: drive, check grant mid-cycle, check broadcast after the edge.
   task automatic cycle(input logic [3:0] req, input logic sq, input logic rs,
                        output logic [3:0] g);
      exp_t e;
      int   idx;
      bus.fu_valid = req;
      squash       = sq;
      reset        = rs;
      drive_bus();
      #4;
      g = model_grant(req, sq, rs);
      check("fu_grant", 64'(bus.fu_grant), 64'(g));
      e     = '{v: 1'b0, chk: 1'b0, val: 32'h0, prf: 6'h0, rob: 5'h0, pc: 32'h0, src: 4'h0};
      idx   = 0;
      for (int i = 0; i < N; i++) if (g[i]) idx = i;
      if (rs) begin
         e.chk = 1'b1;
      end else if (g != 4'b0) begin
         e.v = 1'b1; e.chk = 1'b1; e.src = g;
         e.val = d_val[idx]; e.prf = d_prf[idx]; e.rob = d_rob[idx]; e.pc = d_pc[idx];
      end
      q.push_back(e);
      if (rs) m_ptr = 0;
`ifdef CDB_ROUND_ROBIN_EN
      else if (g != 4'b0) m_ptr = (idx == N-1) ? 0 : idx + 1;
`endif
      @(posedge clock);
      #1;
      if (q.size() == 0) begin
         check("scoreboard_empty", 64'(1), 64'(0));
      end else begin
         e = q.pop_front();
         check("cdb_valid", 64'(bus.cdb_valid), 64'(e.v));
         check("cdb_source", 64'(bus.cdb_source), 64'(e.src));
         if (e.chk) begin
            check("cdb_value", 64'(bus.cdb_value), 64'(e.val));
            check("cdb_prf_idx", 64'(bus.cdb_prf_idx), 64'(e.prf));
            check("cdb_rob_idx", 64'(bus.cdb_rob_idx), 64'(e.rob));
            check("cdb_PC", 64'(bus.cdb_PC), 64'(e.pc));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] g;
      logic [3:0] pend;
      logic [3:0] fresh;
      logic [3:0] seq[5];
      logic       sq;

      for (int i = 0; i < N; i++) set_fu(i, 32'h0, 6'h0, 5'h0, 32'h0);
      bus.fu_valid = '0;

      // Reset state
      cycle(4'b0000, 1'b0, 1'b1, g);
      cycle(4'b1111, 1'b0, 1'b1, g);

      // Single MUL request
      set_fu(FU_MUL, 32'h0000_0042, 6'd5, 5'd3, 32'h0000_1004);
      cycle(4'b0010, 1'b0, 1'b0, g);
      check("single_grant", 64'(g), 64'(4'b0010));

      // All four continuously requesting, from a fresh pointer
      cycle(4'b0000, 1'b0, 1'b1, g);
      for (int i = 0; i < N; i++)
         set_fu(i, 32'hA000_0000 + 32'(i), 6'(10 + i), 5'(20 + i), 32'h8000_0000 + 32'(4*i));
`ifdef CDB_ROUND_ROBIN_EN
      seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
      seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
      for (int c = 0; c < 5; c++) begin
         cycle(4'b1111, 1'b0, 1'b0, g);
         check("all_valid_seq", 64'(g), 64'(seq[c]));
      end

      // Squash suppresses grant, then FU 1 wins
      cycle(4'b0110, 1'b1, 1'b0, g);
      check("squash_grant", 64'(g), 64'(4'b0000));
      cycle(4'b0110, 1'b0, 1'b0, g);
      check("post_squash", 64'(g), 64'(4'b0010));

      // Reset pulse mid-operation
      cycle(4'b0010, 1'b0, 1'b0, g);
      cycle(4'b0011, 1'b0, 1'b1, g);
      cycle(4'b0011, 1'b0, 1'b0, g);
      check("post_reset_alu", 64'(g), 64'(4'b0001));

      // Idle
      for (int c = 0; c < 3; c++) cycle(4'b0000, 1'b0, 1'b0, g);

      // Random traffic: FUs hold valid and data until granted
      pend = 4'b0000;
      for (int c = 0; c < 40; c++) begin
         fresh = 4'($urandom_range(0, 15)) & ~pend;
         for (int i = 0; i < N; i++)
            if (fresh[i])
               set_fu(i, $urandom(), 6'($urandom()), 5'($urandom()), $urandom());
         pend = pend | fresh;
         sq   = ($urandom_range(0, 7) == 0);
         cycle(pend, sq, 1'b0, g);
         pend = pend & ~g;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
